// File: rtl/present_pkg.sv
// present_pkg
// Shared definitions for the PRESENT-style SPN datapath (p-layer, S-box layer
// and key schedule).
//   STATE_W      : cipher state width in bits.
//   p_dir_e      : permutation direction selector encoding.
//   p_index      : forward bit-permutation destination index P(i).
//   p_inv_index  : inverse bit-permutation destination index P^-1(i).
package present_pkg;

    localparam int STATE_W = 64;

    typedef enum logic {
        DIR_FWD = 1'b0,
        DIR_INV = 1'b1
    } p_dir_e;

    // Forward destination of source bit i in a w-bit state. The top bit is a
    // fixed point; every other bit is scaled by w/4 modulo (w-1).
    function automatic int p_index(input int i, input int w);
        int r;
        if (i == (w - 32'sd1)) begin
            r = w - 32'sd1;
        end else begin
            r = (i * (w / 32'sd4)) % (w - 32'sd1);
        end
        return r;
    endfunction

    // Inverse destination of source bit i. Because (w/4)*4 = w = 1 mod (w-1),
    // multiplying by 4 undoes the forward scaling; the top bit stays fixed.
    function automatic int p_inv_index(input int i, input int w);
        int r;
        if (i == (w - 32'sd1)) begin
            r = w - 32'sd1;
        end else begin
            r = (i * 32'sd4) % (w - 32'sd1);
        end
        return r;
    endfunction

endpackage

// File: rtl/p_layer_net.sv
// p_layer_net
// Purely combinational bit-permutation network. Both directions are plain
// wiring; a 2:1 mux picks the requested one.
//   WIDTH          : state width, a power of two and at least 16.
//   original       : state word before permutation.
//   inverse        : 0 = forward P, 1 = inverse P^-1.
//   permuted_comb  : permuted state word (combinational).
module p_layer_net
    import present_pkg::*;
#(
    parameter int WIDTH = STATE_W
) (
    input  logic [WIDTH-1:0] original,
    input  logic             inverse,
    output logic [WIDTH-1:0] permuted_comb
);

    logic [WIDTH-1:0] fwd_s;
    logic [WIDTH-1:0] inv_s;

    // Each source bit is routed to exactly one destination in each direction,
    // so every bit of fwd_s and inv_s has a single driver.
    for (genvar i = 0; i < WIDTH; i++) begin : g_wire
        localparam int FWD_DST = p_index(i, WIDTH);
        localparam int INV_DST = p_inv_index(i, WIDTH);
        assign fwd_s[FWD_DST] = original[i];
        assign inv_s[INV_DST] = original[i];
    end

    // Direction mux.
    always_comb begin
        permuted_comb = fwd_s;
        case (p_dir_e'(inverse))
            DIR_FWD: permuted_comb = fwd_s;
            DIR_INV: permuted_comb = inv_s;
            default: permuted_comb = fwd_s;
        endcase
    end

endmodule

// File: rtl/p_layer.sv
// p_layer
// Registered bit-permutation layer of one cipher round. A word presented with
// in_valid is permuted (forward or inverse) and appears on `permuted` one
// cycle later with out_valid set. Without in_valid the output word holds and
// out_valid drops. No backpressure.
//   clk        : rising-edge clock.
//   rst_n      : asynchronous active-low reset.
//   in_valid   : original carries a word this cycle.
//   inverse    : 0 = forward P, 1 = inverse P^-1, sampled with original.
//   original   : state word before permutation.
//   out_valid  : permuted holds a freshly computed word.
//   permuted   : registered state word after permutation.
module p_layer
    import present_pkg::*;
#(
    parameter int WIDTH = STATE_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             inverse,
    input  logic [WIDTH-1:0] original,
    output logic             out_valid,
    output logic [WIDTH-1:0] permuted
);

    logic [WIDTH-1:0] permuted_comb_s;
    logic [WIDTH-1:0] permuted_r;
    logic             out_valid_r;

    p_layer_net #(
        .WIDTH (WIDTH)
    ) u_net (
        .original      (original),
        .inverse       (inverse),
        .permuted_comb (permuted_comb_s)
    );

    // Output register and valid flag; the word is only replaced on a valid
    // input so downstream logic can keep reading it after out_valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            permuted_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= in_valid;
            if (in_valid) begin
                permuted_r <= permuted_comb_s;
            end else begin
                permuted_r <= permuted_r;
            end
        end
    end

    assign permuted  = permuted_r;
    assign out_valid = out_valid_r;

endmodule

// File: tb/tb_p_layer.sv
// tb_p_layer
// Self-checking bench for p_layer (WIDTH=64). Inputs are driven on the falling
// edge; a single compare process samples the inputs at each rising edge,
// computes the expected output from a behavioural permutation model and
// checks the DUT shortly after the edge.
module tb_p_layer;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         inverse;
    logic [W-1:0] original;
    logic         out_valid;
    logic [W-1:0] permuted;

    int checks;
    int errors;

    logic         exp_valid;
    logic [W-1:0] exp_data;
    logic         cmp_en;

    p_layer #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .inverse   (inverse),
        .original  (original),
        .out_valid (out_valid),
        .permuted  (permuted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model straight from the bit-mapping rule:
    // forward sends bit i to (i*W/4) mod (W-1); inverse fetches bit i from there.
    function automatic logic [W-1:0] model(input logic [W-1:0] x, input logic inv);
        logic [W-1:0] r;
        int d;
        r = '0;
        for (int i = 0; i < W - 1; i++) begin
            d = (i * (W / 4)) % (W - 1);
            if (!inv) r[d] = x[i];
            else      r[i] = x[d];
        end
        r[W-1] = x[W-1];
        return r;
    endfunction

    function automatic logic [W-1:0] rand64();
        return {$urandom(), $urandom()};
    endfunction

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Per-cycle compare: sample inputs at the edge, predict, then check.
    always @(posedge clk) begin
        logic         s_v;
        logic         s_inv;
        logic [W-1:0] s_w;
        s_v   = in_valid;
        s_inv = inverse;
        s_w   = original;
        if (!rst_n) begin
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            exp_valid = s_v;
            if (s_v) exp_data = model(s_w, s_inv);
        end
        #1;
        if (cmp_en) begin
            check("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            check("permuted", permuted, exp_data);
            if (exp_valid && rst_n)
                check("popcount", 64'($countones(permuted)), 64'($countones(s_w)));
        end
    end

    task automatic drive(input logic v, input logic inv, input logic [W-1:0] w);
        @(negedge clk);
        in_valid = v;
        inverse  = inv;
        original = w;
    endtask

    // Drive one word, then check the DUT against a hand-computed literal
    // and check the model against the same literal.
    task automatic lit(input string name, input logic inv, input logic [W-1:0] w,
                       input logic [W-1:0] req);
        drive(1'b1, inv, w);
        @(posedge clk);
        #2;
        check(name, permuted, req);
        check({name, "_model"}, model(w, inv), req);
    endtask

    initial begin
        logic [W-1:0] w;
        logic [W-1:0] fw;
        checks   = 0;
        errors   = 0;
        cmp_en   = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        inverse  = 1'b0;
        original = '0;

        // Reset state
        #12;
        check("reset_permuted", permuted, 64'h0);
        check("reset_valid", {63'd0, out_valid}, 64'd0);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        // Literal vectors
        lit("fwd_bit1",  1'b0, 64'h0000000000000002, 64'h0000000000010000);
        lit("fwd_bit4",  1'b0, 64'h0000000000000010, 64'h0000000000000002);
        lit("fwd_bit63", 1'b0, 64'h8000000000000000, 64'h8000000000000000);
        lit("fwd_nib0",  1'b0, 64'h000000000000000F, 64'h0001000100010001);
        lit("inv_nib0",  1'b1, 64'h0001000100010001, 64'h000000000000000F);
        lit("zero",      1'b0, 64'h0000000000000000, 64'h0000000000000000);
        lit("ones",      1'b0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);
        lit("ones_inv",  1'b1, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF);

        // Streaming: 5 back-to-back words with alternating direction, then a
        // gap cycle in which the word must hold and out_valid must drop.
        for (int k = 0; k < 5; k++) drive(1'b1, k[0], rand64());
        drive(1'b0, 1'b0, rand64());
        drive(1'b0, 1'b1, rand64());

        // Random traffic with random valid and direction.
        for (int k = 0; k < 300; k++)
            drive(1'($urandom_range(0, 3) != 0), 1'($urandom()), rand64());

        // Forward-then-inverse round trip.
        for (int k = 0; k < 1000; k++) begin
            w = rand64();
            drive(1'b1, 1'b0, w);
            @(posedge clk);
            #2;
            fw = permuted;
            drive(1'b1, 1'b1, fw);
            @(posedge clk);
            #2;
            check("roundtrip", permuted, w);
        end

        // Asynchronous reset mid-stream, away from any clock edge.
        drive(1'b1, 1'b0, rand64());
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_permuted", permuted, 64'h0);
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        drive(1'b1, 1'b0, 64'h0000000000000010);
        drive(1'b1, 1'b0, 64'h0000000000000010);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
        check("post_rst_first", permuted, 64'h0000000000000002);
        check("post_rst_valid", {63'd0, out_valid}, 64'd1);
        for (int k = 0; k < 20; k++) drive(1'b1, 1'($urandom()), rand64());
        drive(1'b0, 1'b0, '0);
        @(posedge clk);
        #3;
        cmp_en = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
